fcw_slew_ctrl: RTL and testbench

Frequency-control-word slew limiter that sits directly upstream of the phase-accumulator clock divider and drives its 32-bit phase increment input.
- Accepts a target FCW over a valid/ready handshake.
- Walks the live increment toward the target in bounded steps at a programmable update rate, so the generated clock never sees a frequency jump larger than the step.
- Reports ramp-in-progress and a one-cycle completion pulse.

---
 rtl/fcw_slew_pkg.sv | 19 +
 rtl/fcw_tick_gen.sv | 28 ++
 rtl/fcw_slew_ctrl.sv | 120 ++++++++++++
 tb/tb_fcw_slew_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fcw_slew_pkg.sv
// Shared types and default widths for the FCW slew limiter.
package fcw_slew_pkg;

  localparam int unsigned FCW_W_DEF  = 32;
  localparam int unsigned STEP_W_DEF = 16;
  localparam int unsigned DIV_W_DEF  = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } state_t;

  typedef struct packed {
    logic [FCW_W_DEF-1:0]  fcw;
    logic [STEP_W_DEF-1:0] step;
    logic [DIV_W_DEF-1:0]  div;
  } slew_req_t;

endpackage

// File: rtl/fcw_tick_gen.sv
// Update-rate prescaler: counts while enabled and emits a one-cycle tick
// when the count equals div, then wraps to zero. clr has priority.
module fcw_tick_gen #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] count;

  assign tick = en && (count == div);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr || tick) begin
      count <= '0;
    end else if (en) begin
      count <= count + {{(DIV_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/fcw_slew_ctrl.sv
// Slews the phase-accumulator increment toward a requested FCW in bounded steps.
// Optional macro FCW_SLEW_ABORT_EN adds an abort input that freezes an active ramp.
module fcw_slew_ctrl
  import fcw_slew_pkg::*;
#(
  parameter int unsigned FCW_W  = FCW_W_DEF,
  parameter int unsigned STEP_W = STEP_W_DEF,
  parameter int unsigned DIV_W  = DIV_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tgt_valid,
  output logic              tgt_ready,
  input  logic [FCW_W-1:0]  tgt_fcw,
  input  logic [STEP_W-1:0] tgt_step,
  input  logic [DIV_W-1:0]  tgt_div,
`ifdef FCW_SLEW_ABORT_EN
  input  logic              abort,
`endif
  output logic [FCW_W-1:0]  phase_incr,
  output logic              busy,
  output logic              done
);

  state_t state_q, state_d;

  logic [FCW_W-1:0]  tgt_q;
  logic [STEP_W-1:0] step_q;
  logic [DIV_W-1:0]  div_q;

  logic             accept, hit, jump;
  logic             tick, upd, final_upd, abort_hit, up;
  logic [FCW_W-1:0] step_fcw;
  logic [FCW_W:0]   diff;

`ifdef FCW_SLEW_ABORT_EN
  assign abort_hit = (state_q == RAMP) && abort;
`else
  assign abort_hit = 1'b0;
`endif

  assign accept = tgt_valid && (state_q == IDLE);
  assign hit    = (tgt_fcw == phase_incr);
  assign jump   = (tgt_step == '0);

  fcw_tick_gen #(
    .DIV_W (DIV_W)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept || abort_hit),
    .en    (state_q == RAMP),
    .div   (div_q),
    .tick  (tick)
  );

  // Distance is formed one bit wider so the comparison against the step can
  // never wrap; the landing case then guarantees no overshoot past the target.
  assign up        = (tgt_q > phase_incr);
  assign diff      = up ? ({1'b0, tgt_q} - {1'b0, phase_incr})
                        : ({1'b0, phase_incr} - {1'b0, tgt_q});
  assign step_fcw  = {{(FCW_W-STEP_W){1'b0}}, step_q};
  assign upd       = tick && !abort_hit;
  assign final_upd = upd && (diff <= {1'b0, step_fcw});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && !hit && !jump) state_d = RAMP;
      RAMP:    if (abort_hit || final_upd)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tgt_ready = (state_q == IDLE);
    busy      = (state_q == RAMP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_incr <= '0;
      done       <= 1'b0;
      tgt_q      <= '0;
      step_q     <= '0;
      div_q      <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        tgt_q  <= tgt_fcw;
        step_q <= tgt_step;
        div_q  <= tgt_div;
        if (hit) begin
          done <= 1'b1;
        end else if (jump) begin
          phase_incr <= tgt_fcw;
          done       <= 1'b1;
        end
      end else if (upd) begin
        if (final_upd) begin
          phase_incr <= tgt_q;
          done       <= 1'b1;
        end else if (up) begin
          phase_incr <= phase_incr + step_fcw;
        end else begin
          phase_incr <= phase_incr - step_fcw;
        end
      end
    end
  end

endmodule

// File: tb/tb_fcw_slew_ctrl.sv
// Scoreboard bench for fcw_slew_ctrl: a countdown-based behavioural model
// predicts each cycle's outputs, queued at drive time and popped after the edge.
module tb_fcw_slew_ctrl;

  localparam int unsigned FCW_W  = 32;
  localparam int unsigned STEP_W = 16;
  localparam int unsigned DIV_W  = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              tgt_valid = 1'b0;
  logic              tgt_ready;
  logic [FCW_W-1:0]  tgt_fcw = '0;
  logic [STEP_W-1:0] tgt_step = '0;
  logic [DIV_W-1:0]  tgt_div = '0;
  logic              abort = 1'b0;
  logic [FCW_W-1:0]  phase_incr;
  logic              busy;
  logic              done;

  always #5 clk = ~clk;

  fcw_slew_ctrl #(
    .FCW_W  (FCW_W),
    .STEP_W (STEP_W),
    .DIV_W  (DIV_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tgt_valid  (tgt_valid),
    .tgt_ready  (tgt_ready),
    .tgt_fcw    (tgt_fcw),
    .tgt_step   (tgt_step),
    .tgt_div    (tgt_div),
`ifdef FCW_SLEW_ABORT_EN
    .abort      (abort),
`endif
    .phase_incr (phase_incr),
    .busy       (busy),
    .done       (done)
  );

  typedef struct {
    longint pi;
    bit     done;
    bit     busy;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;

  longint m_pi = 0, m_tgt = 0;
  int     m_step = 0, m_div = 0, m_wait = 0;
  bit     m_busy = 1'b0, m_done = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pi = 0; m_tgt = 0; m_step = 0; m_div = 0; m_wait = 0;
    m_busy = 1'b0; m_done = 1'b0;
    sb.delete();
  endtask

  // Predicts the effect of the coming rising edge from the current inputs.
  task automatic model_edge();
    longint d;
    m_done = 1'b0;
    if (!m_busy) begin
      if (tgt_valid) begin
        if (longint'(tgt_fcw) == m_pi) begin
          m_done = 1'b1;
        end else if (tgt_step == 0) begin
          m_pi   = longint'(tgt_fcw);
          m_done = 1'b1;
        end else begin
          m_busy = 1'b1;
          m_tgt  = longint'(tgt_fcw);
          m_step = int'(tgt_step);
          m_div  = int'(tgt_div);
          m_wait = int'(tgt_div);
        end
      end
    end else if (abort) begin
      m_busy = 1'b0;
    end else if (m_wait > 0) begin
      m_wait--;
    end else begin
      d = m_tgt - m_pi;
      if (d <= m_step && d >= -m_step) begin
        m_pi   = m_tgt;
        m_done = 1'b1;
        m_busy = 1'b0;
      end else if (d > 0) begin
        m_pi = m_pi + m_step;
      end else begin
        m_pi = m_pi - m_step;
      end
      m_wait = m_div;
    end
  endtask

  task automatic cycle();
    exp_t e;
    model_edge();
    sb.push_back('{m_pi, m_done, m_busy});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_eq("phase_incr", 64'(phase_incr), e.pi);
    check_eq("done", 64'(done), 64'(e.done));
    check_eq("busy", 64'(busy), 64'(e.busy));
    check_eq("tgt_ready", 64'(tgt_ready), 64'(!e.busy));
    if (done) n_done++;
  endtask

  task automatic request(input logic [FCW_W-1:0] f, input logic [STEP_W-1:0] s,
                         input logic [DIV_W-1:0] dv);
    tgt_fcw   = f;
    tgt_step  = s;
    tgt_div   = dv;
    tgt_valid = 1'b1;
    cycle();
    tgt_valid = 1'b0;
    tgt_fcw   = $urandom;
    tgt_step  = 16'($urandom);
    tgt_div   = 8'($urandom);
  endtask

  task automatic run_out(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (!m_busy) break;
      cycle();
    end
    if (m_busy) check_eq("ramp_timeout", 64'(busy), 64'(0));
    cycle();
  endtask

  initial begin
    model_reset();
    #12;
    check_eq("rst_phase_incr", 64'(phase_incr), 64'(0));
    check_eq("rst_tgt_ready", 64'(tgt_ready), 64'(1));
    check_eq("rst_busy", 64'(busy), 64'(0));
    check_eq("rst_done", 64'(done), 64'(0));
    rst_n = 1'b1;
    repeat (3) cycle();

    n_done = 0;
    request(32'd1000, 16'd300, 8'd0);
    run_out(50);
    check_eq("up_final", 64'(phase_incr), 64'd1000);
    check_eq("up_done_count", 64'(n_done), 64'd1);

    n_done = 0;
    request(32'd0, 16'd400, 8'd3);
    run_out(100);
    check_eq("down_final", 64'(phase_incr), 64'd0);
    check_eq("down_done_count", 64'(n_done), 64'd1);

    n_done = 0;
    request(32'hFFFF_FFFF, 16'd0, 8'd5);
    repeat (2) cycle();
    check_eq("jump_value", 64'(phase_incr), 64'hFFFF_FFFF);
    request(32'hFFFF_FFFF, 16'd100, 8'd0);
    repeat (2) cycle();
    check_eq("equal_done_count", 64'(n_done), 64'd2);

    request(32'hFFFF_FF00, 16'd0, 8'd0);
    cycle();
    request(32'hFFFF_FFFF, 16'hFFFF, 8'd1);
    run_out(20);
    check_eq("top_no_wrap", 64'(phase_incr), 64'hFFFF_FFFF);
    request(32'h0000_0100, 16'd0, 8'd0);
    cycle();
    request(32'h0000_0000, 16'hFFFF, 8'd0);
    run_out(20);
    check_eq("bottom_no_wrap", 64'(phase_incr), 64'd0);

    n_done = 0;
    request(32'd1000, 16'd300, 8'd2);
    tgt_valid = 1'b1;
    tgt_fcw   = 32'd5;
    tgt_step  = 16'd1;
    repeat (6) cycle();
    tgt_valid = 1'b0;
    run_out(50);
    check_eq("stall_final", 64'(phase_incr), 64'd1000);
    check_eq("stall_done_count", 64'(n_done), 64'd1);

    request(32'd0, 16'd0, 8'd0);
    cycle();
    n_done = 0;
    request(32'd1000, 16'd300, 8'd2);
    repeat (4) cycle();
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_phase_incr", 64'(phase_incr), 64'd0);
    check_eq("midrst_busy", 64'(busy), 64'd0);
    check_eq("midrst_ready", 64'(tgt_ready), 64'd1);
    check_eq("midrst_done", 64'(done), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) cycle();
    check_eq("midrst_done_count", 64'(n_done), 64'd0);

`ifdef FCW_SLEW_ABORT_EN
    n_done = 0;
    request(32'd1000, 16'd300, 8'd0);
    repeat (2) cycle();
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    repeat (3) cycle();
    check_eq("abort_hold", 64'(phase_incr), 64'd600);
    check_eq("abort_done_count", 64'(n_done), 64'd0);
    abort = 1'b1;
    repeat (2) cycle();
    abort = 1'b0;
`endif

    for (int k = 0; k < 12; k++) begin
      logic [STEP_W-1:0] s;
      s = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(20000, 65535));
      request(32'($urandom_range(0, 1000000)), s, 8'($urandom_range(0, 3)));
      run_out(400);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1);
  end

endmodule
